// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, command characters, bit timing.
// Used by the RX core and the command decoder; the TX side derives its bit period the same way.
// No logic here, only types, constants and a constant function.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_1 = 8'h31;

  // Clock cycles per serial bit; integer division, callers keep the result >= 4.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, bit-timing FSM, registered byte and pulses.
// Latency: rx_valid 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start-bit falling edge.
// No backpressure: every good frame pulses rx_valid once; the consumer must take it that cycle.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       done_o,
  output logic [7:0] done_byte_o
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_byte_q;
  logic          rx_valid_q;
  logic          frame_err_q;

  assign rx_s = sync_q[1];

  // A good stop sample this cycle; lets the decoder update on the same edge as rx_valid.
  assign done_o      = (state_q == STOP) && (cnt_q == CNT_LAST) && rx_s;
  assign done_byte_o = shift_q;

  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_i};
  end

  // Receive FSM with bit counter, shift register and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        BREAK: begin
          // Stay here while the line is held low so a long break reports only once.
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_cmd.sv
// UART command receiver: exposes each byte and drives act_out from ASCII '1'/'0'.
// Latency: act_out and cmd_err change on the same edge rx_valid rises.
// No backpressure: commands are decoded as they arrive; nothing is buffered.
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       act_out
);

  logic       done;
  logic [7:0] done_byte;
  logic       act_q;
  logic       cmd_err_q;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_in),
    .rx_byte_o   (rx_byte),
    .rx_valid_o  (rx_valid),
    .frame_err_o (frame_err),
    .done_o      (done),
    .done_byte_o (done_byte)
  );

  assign act_out = act_q;
  assign cmd_err = cmd_err_q;

  // Command decode: '1' sets, '0' clears, anything else flags an error and leaves act_out alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= 1'b0;
      if (done) begin
        if (done_byte == ASCII_1)      act_q     <= 1'b1;
        else if (done_byte == ASCII_0) act_q     <= 1'b0;
        else                           cmd_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd at 16 clocks per bit.
// Frames are driven as serial waveforms; a queue of expected bytes models the receiver.
// Pulses are checked when they appear and event counts are reconciled per scenario.
module tb_uart_rx_cmd;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       cmd_err;
  logic       act_out;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         st_q[$];
  logic       m_act  = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int exp_valid = 0, exp_ferr = 0, exp_cmd = 0;
  int obs_valid = 0, obs_ferr = 0, obs_cmd = 0;

  uart_rx_cmd #(
    .CLK_FREQ (160),
    .BAUD     (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .cmd_err   (cmd_err),
    .act_out   (act_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: compares every pulse against the model as it happens.
  always @(negedge clk) begin : mon
    logic [7:0] eb;
    int st;
    int lat;
    if (!rst) begin
      if (rx_valid || frame_err || cmd_err)
        chk("pulse_excl", {30'd0, rx_valid & frame_err, cmd_err & ~rx_valid}, 32'd0);
      if (cmd_err) obs_cmd++;
      if (rx_valid) begin
        obs_valid++;
        chk("valid_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          st = st_q.pop_front();
          if (eb == 8'h31)      m_act = 1'b1;
          else if (eb == 8'h30) m_act = 1'b0;
          m_byte = eb;
          chk("rx_byte", rx_byte, eb);
          chk("act_out", act_out, m_act);
          chk("cmd_err", cmd_err, (eb != 8'h30) && (eb != 8'h31));
          // st is the cycle count before the first edge that sees the falling rx_in
          lat = cyc - st - 1;
          chk("latency", lat, (lat >= 153 && lat <= 155) ? lat : 154);
        end
      end
      if (frame_err) begin
        obs_ferr++;
        chk("ferr_byte_held", rx_byte, m_byte);
        chk("ferr_act_held", act_out, m_act);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; a low stop bit leaves the line low for the caller to release.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    if (stop_ok) begin
      exp_q.push_back(b);
      st_q.push_back(cyc);
      exp_valid++;
      if (b != 8'h30 && b != 8'h31) exp_cmd++;
    end else begin
      exp_ferr++;
    end
    rx_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      idle(CPB);
    end
    rx_in = stop_ok;
    idle(CPB);
    if (stop_ok) idle(gap);
  endtask

  task automatic check_counts(input string tag);
    idle(30);
    chk({tag, "_nvalid"}, obs_valid, exp_valid);
    chk({tag, "_nferr"}, obs_ferr, exp_ferr);
    chk({tag, "_ncmd"}, obs_cmd, exp_cmd);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_act"}, act_out, m_act);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte"}, rx_byte, 8'h00);
    chk({tag, "_pulses"}, {rx_valid, frame_err, cmd_err}, 3'b000);
    chk({tag, "_act"}, act_out, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    st_q.delete();
    m_act  = 1'b0;
    m_byte = 8'h00;
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    rx_in = 1'b1;
    rst   = 1'b1;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Quiet line: no pulses at all
    idle(200);
    check_counts("idle");

    // Reset pulse while idle
    rst = 1'b1;
    idle(2);
    check_reset_outputs("reset_idle");
    rst = 1'b0;
    idle(5);

    // '1' then '0' back to back
    send_frame(8'h31, 1'b1, 0);
    send_frame(8'h30, 1'b1, 0);
    check_counts("cmd10");

    // Non-command byte while act_out is high
    send_frame(8'h31, 1'b1, 7);
    send_frame(8'h41, 1'b1, 3);
    check_counts("cmd_a");

    // Bad stop bit, long break, then a good '0'
    send_frame(8'h31, 1'b0, 0);
    idle(100);
    rx_in = 1'b1;
    idle(20);
    check_counts("break");
    send_frame(8'h30, 1'b1, 5);
    check_counts("after_break");

    // Short glitch must be ignored
    rx_in = 1'b0;
    idle(5);
    rx_in = 1'b1;
    idle(40);
    check_counts("glitch");
    send_frame(8'h31, 1'b1, 5);
    check_counts("after_glitch");

    // Reset in the middle of data bit 4 of '1'
    b = 8'h31;
    rx_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_in = b[i];
      idle(CPB);
    end
    rx_in = b[4];
    idle(CPB / 2);
    rst = 1'b1;
    rx_in = 1'b1;
    model_reset();
    idle(3);
    check_reset_outputs("reset_mid");
    rst = 1'b0;
    idle(20);
    send_frame(8'h30, 1'b1, 5);
    check_counts("after_reset_mid");

    // Randomized traffic: commands, other bytes, bad stops and varied gaps
    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0:       b = 8'h30;
        1:       b = 8'h31;
        default: b = 8'($urandom_range(0, 255));
      endcase
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, $urandom_range(0, 25));
      if (!ok) begin
        idle($urandom_range(10, 60));
        rx_in = 1'b1;
        idle($urandom_range(5, 30));
      end
    end
    check_counts("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
UART receiver and command decoder: the inbound counterpart of the sensor-to-ASCII transmit path. It receives 8N1 serial frames from the host and exposes each byte. ASCII '1'/'0' set or clear a registered actuator output. It sits between the board RX pin and the digital actuator, in the same clock domain as the TX path.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD, 9600, line rate in bits/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 4)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx_in  input  1  serial line, asynchronous to clk, idle high
rx_byte  output  8  last received byte, held until the next good frame
rx_valid  output  1  one-cycle pulse, rx_byte updated this cycle
frame_err  output  1  one-cycle pulse, stop bit sampled low
cmd_err  output  1  one-cycle pulse, good frame whose byte is not 0x30/0x31
act_out  output  1  actuator level, registered

Behaviour:
- Reset (async, active-high):
  - rx_byte=0x00; rx_valid, frame_err, cmd_err, act_out = 0.
  - Both synchronizer flops = 1; FSM = IDLE; counters = 0.
  - Asserting reset mid-frame aborts the frame with no pulses. After release, a new start bit is needed.
- rx_in passes through a 2-flop synchronizer (rx_s). All timing below is relative to rx_s.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; reloads at 0 on each state entry.
- Bit index: 3 bits; data is LSB first.
- FSM:
  - IDLE: wait for rx_s=0 → START.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - 0 → DATA, bit index 0.
    - 1 → IDLE (glitch rejected, no pulse).
  - DATA: every CLKS_PER_BIT cycles, shift rx_s into shift register bit [index]. After index 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles (mid stop bit), sample rx_s.
    - 1: load rx_byte, pulse rx_valid → IDLE.
    - 0: pulse frame_err, rx_byte unchanged → BREAK.
  - BREAK: wait for rx_s=1 → IDLE. A held-low line yields exactly one frame_err.
- Decode, registered on the same edge rx_valid rises:
  - byte 0x31 → act_out=1.
  - byte 0x30 → act_out=0.
  - any other byte → act_out unchanged, cmd_err=1 for that cycle.
  - No decode on frame_err.
- Latency: from the rx_in falling edge, the rx_valid/act_out edge lands 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles later, ±1.
- Pulse exclusivity: rx_valid and frame_err are never high together. cmd_err only occurs with rx_valid.
- Back-to-back frames: a start bit arriving immediately after the stop sample is accepted. IDLE is reached on the stop-sample edge, so inter-frame gap tolerance is at least half a bit.
- Repeating the same command: act_out is re-written with the same value, no glitch. rx_valid pulses every frame.

Decomposition:
- Package uart_pkg:
  - State enum {IDLE, START, DATA, STOP, BREAK}.
  - Constants ASCII_0=8'h30 and ASCII_1=8'h31.
  - Function deriving CLKS_PER_BIT; shared with the TX side.
- Sub-module uart_rx_core: synchronizer + FSM, outputs rx_byte/rx_valid/frame_err.
- uart_rx_cmd: instantiates uart_rx_core and contains the decode/act_out register.

Test Plan:
- Setup: CLK_FREQ=160, BAUD=10 (16 clks/bit) for all scenarios.
- Reset: rst pulse mid-IDLE → all outputs 0, rx_byte=0x00. rx_in held high 200 cycles → no pulses.
- Frame 0x31 then 0x30 → first frame: rx_valid pulse, rx_byte=0x31, act_out=1 on the same edge. Second frame: act_out=0. cmd_err stays 0. Check the latency window 154±1 cycles.
- Frame 0x41 ('A') with act_out=1 → rx_valid and cmd_err pulse together, rx_byte=0x41, act_out stays 1.
- Frame 0x31 with stop bit forced low, then line held low 100 cycles, then high, then a good 0x30 → exactly one frame_err, no rx_valid, act_out unchanged. Then 0x30 is received normally.
- Glitch: rx_in low for 5 cycles (< 8) then high → no pulses, FSM back in IDLE. A following 0x31 frame is received correctly.
- Reset mid-frame: assert rst at data bit 4 of 0x31, release, then send 0x30 → no pulse from the aborted frame. 0x30 decodes, act_out=0.
